// File: rtl/mips_regfile_sb.sv
// mips_regfile_sb
//   Parametrised MIPS register file with a pending-write scoreboard.
//   Decode reads operands and busy bits through NRD combinational read
//   ports and marks destinations busy with the issue strobe. Writeback
//   stores data and clears the busy bit. A separate debug port gives
//   unbypassed access to the stored state.
//
// Parameters
//   DW    data width of each register
//   NREG  number of architectural registers (power of 2, >= 2)
//   AW    address width, must equal log2(NREG)
//   NRD   number of read ports (1..4)
//
// Ports
//   clk       clock, all state updates on the rising edge
//   rst       synchronous active-high reset
//   rd_addr   NRD packed read addresses, port k at [k*AW +: AW]
//   rd_data   NRD packed read data, port k at [k*DW +: DW]
//   rd_busy   bit k = busy bit of the register addressed by port k
//   we/wa/wd  writeback enable, address, data
//   iss       issue strobe, iss_dst = destination of issued instruction
//   dbg_addr  debug read address
//   dbg_data  debug read data (stored value, never bypassed)
//   busy_cnt  registered count of busy registers
//
// Build option
//   WRITE_BYPASS_EN  when defined, a read port addressing the register being
//                    written this cycle returns wd directly.

module mips_regfile_sb #(
  parameter int DW   = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DW-1:0]     wd,
  input  logic              iss,
  input  logic [AW-1:0]     iss_dst,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DW-1:0]     dbg_data,
  output logic [AW:0]       busy_cnt
);

  // Reject inconsistent parameter sets at elaboration time.
  generate
    if (NREG < 2 || (1 << AW) != NREG || $clog2(NREG) != AW) begin : g_bad_aw
      $error("mips_regfile_sb: AW must equal log2(NREG) and NREG must be a power of 2 >= 2");
    end
    if (NRD < 1 || NRD > 4) begin : g_bad_nrd
      $error("mips_regfile_sb: NRD must be in 1..4");
    end
  endgenerate

  logic [DW-1:0]   rf [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic [AW:0]     busy_pop;

  logic write_ok;
  logic issue_ok;

  assign write_ok = we  && (wa      != '0);
  assign issue_ok = iss && (iss_dst != '0);

  // Scoreboard next state: writeback clears, issue sets afterwards so a
  // same-cycle issue to the register being written leaves it busy (the new
  // producer is still outstanding). Register 0 can never become busy.
  always_comb begin
    busy_next = busy;
    if (write_ok) busy_next[wa]      = 1'b0;
    if (issue_ok) busy_next[iss_dst] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Popcount of the post-update busy vector, registered below so busy_cnt
  // moves together with the busy bits themselves.
  always_comb begin
    busy_pop = '0;
    for (int i = 0; i < NREG; i++) begin
      busy_pop = busy_pop + {{AW{1'b0}}, busy_next[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (write_ok) rf[wa] <= wd;
      busy     <= busy_next;
      busy_cnt <= busy_pop;
    end
  end

  // Register 0 is forced to zero on every read path, so its flop contents
  // (including before the first reset) never matter.
  assign dbg_data = (dbg_addr == '0) ? '0 : rf[dbg_addr];

  generate
    for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] addr;
      logic [DW-1:0] stored;
      logic          stored_busy;

      assign addr        = rd_addr[k*AW +: AW];
      assign stored      = (addr == '0) ? '0 : rf[addr];
      assign stored_busy = (addr == '0) ? 1'b0 : busy[addr];

`ifdef WRITE_BYPASS_EN
      // Forward the writeback value; the busy bit drops unless a new
      // producer for the same register issues in this very cycle.
      logic hit;
      assign hit              = write_ok && (addr == wa);
      assign rd_data[k*DW +: DW] = hit ? wd : stored;
      assign rd_busy[k]       = hit ? (iss && (iss_dst == wa)) : stored_busy;
`else
      assign rd_data[k*DW +: DW] = stored;
      assign rd_busy[k]       = stored_busy;
`endif
    end
  endgenerate

endmodule
